// File: rtl/boot_instr_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : boot_instr_mem
// Purpose  : Boot-loaded instruction memory with combinational fetch and NOP fill
// Revision : 1.0
// ----------------------------------------------------------------------------
module boot_instr_mem #(
  parameter int unsigned          DEPTH     = 256,
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      FILL_WORD = 32'h0000_0013,
  localparam int unsigned         AW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reload,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  input  logic [AW+1:0]   A,
  output logic [XLEN-1:0] RD,
  output logic            misaligned,
  output logic            boot_done,
  output logic [AW:0]     ld_count,
  output logic            ld_overflow
);

  localparam logic [AW:0] C_LAST_IDX = (AW+1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW:0]     r_ld_count;
  logic            r_ld_overflow;
  logic            w_accept;
  logic [AW-1:0]   w_idx;
  logic            w_in_prog;
  logic [XLEN-1:0] r_mem [DEPTH];

  // reload wins over a same-edge offer: the word stays with the source
  assign w_accept = ld_valid & (r_state == S_LOAD) & ~reload;

  always_comb begin
    w_state_nxt = r_state;
    if (reload) begin
      w_state_nxt = S_LOAD;
    end else if (w_accept && (ld_last || (r_ld_count == C_LAST_IDX))) begin
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_LOAD;
      r_ld_count    <= '0;
      r_ld_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (reload) begin
        r_ld_count    <= '0;
        r_ld_overflow <= 1'b0;
      end else begin
        if (w_accept) begin
          r_ld_count <= r_ld_count + 1'b1;
        end
        if ((r_state == S_RUN) && ld_valid) begin
          r_ld_overflow <= 1'b1;
        end
      end
    end
  end

  // Array is intentionally unreset; stale words are hidden by the fill rule
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_ld_count[AW-1:0]] <= ld_data;
    end
  end

  assign w_idx      = A[AW+1:2];
  assign w_in_prog  = ({1'b0, w_idx} < r_ld_count);
  assign RD         = ((r_state == S_RUN) && w_in_prog) ? r_mem[w_idx] : FILL_WORD;
  assign misaligned = |A[1:0];

  assign ld_ready    = (r_state == S_LOAD);
  assign boot_done   = (r_state == S_RUN);
  assign ld_count    = r_ld_count;
  assign ld_overflow = r_ld_overflow;

endmodule
`default_nettype wire

// File: tb/tb_boot_instr_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_boot_instr_mem
// Purpose  : Bench for boot_instr_mem, DEPTH=256 and DEPTH=4 instances side by side
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_boot_instr_mem;

  localparam logic [31:0] FILL = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reload = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_last = 1'b0;
  logic [31:0] ld_data = '0;
  logic [9:0]  a_bus = '0;

  logic [31:0] rd_b, rd_s;
  logic        mis_b, mis_s, rdy_b, rdy_s, done_b, done_s, ovf_b, ovf_s;
  logic [8:0]  cnt_b;
  logic [2:0]  cnt_s;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  boot_instr_mem #(.DEPTH(256), .XLEN(32), .FILL_WORD(FILL)) u_big (
    .clk(clk), .rst_n(rst_n), .reload(reload), .ld_valid(ld_valid),
    .ld_ready(rdy_b), .ld_data(ld_data), .ld_last(ld_last), .A(a_bus),
    .RD(rd_b), .misaligned(mis_b), .boot_done(done_b), .ld_count(cnt_b),
    .ld_overflow(ovf_b)
  );

  boot_instr_mem #(.DEPTH(4), .XLEN(32), .FILL_WORD(FILL)) u_small (
    .clk(clk), .rst_n(rst_n), .reload(reload), .ld_valid(ld_valid),
    .ld_ready(rdy_s), .ld_data(ld_data), .ld_last(ld_last), .A(a_bus[3:0]),
    .RD(rd_s), .misaligned(mis_s), .boot_done(done_s), .ld_count(cnt_s),
    .ld_overflow(ovf_s)
  );

  // Reference: per instance, the list of loaded program words plus two flags
  int          dep [2] = '{256, 4};
  logic [31:0] prog [2][256];
  int          cnt [2];
  bit          running [2];
  bit          ovf [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0;
      running[k] = 1'b0;
      ovf[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reload) begin
        cnt[k] = 0;
        running[k] = 1'b0;
        ovf[k] = 1'b0;
      end else if (ld_valid) begin
        if (!running[k]) begin
          prog[k][cnt[k]] = ld_data;
          cnt[k] = cnt[k] + 1;
          if (ld_last || cnt[k] == dep[k]) running[k] = 1'b1;
        end else begin
          ovf[k] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [9:0] a);
    int w;
    w = int'(a[9:2]) % dep[k];
    return (running[k] && w < cnt[k]) ? prog[k][w] : FILL;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [9:0] a);
    a_bus = a;
    #1;
    chk("big.RD",          rd_b,                  exp_rd(0, a));
    chk("big.misaligned",  {31'b0, mis_b},        {31'b0, |a[1:0]});
    chk("big.ld_ready",    {31'b0, rdy_b},        {31'b0, !running[0]});
    chk("big.boot_done",   {31'b0, done_b},       {31'b0, running[0]});
    chk("big.ld_count",    {23'b0, cnt_b},        32'(cnt[0]));
    chk("big.ld_overflow", {31'b0, ovf_b},        {31'b0, ovf[0]});
    chk("small.RD",          rd_s,                exp_rd(1, a));
    chk("small.misaligned",  {31'b0, mis_s},      {31'b0, |a[1:0]});
    chk("small.ld_ready",    {31'b0, rdy_s},      {31'b0, !running[1]});
    chk("small.boot_done",   {31'b0, done_s},     {31'b0, running[1]});
    chk("small.ld_count",    {29'b0, cnt_s},      32'(cnt[1]));
    chk("small.ld_overflow", {31'b0, ovf_s},      {31'b0, ovf[1]});
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    ld_valid = v;
    ld_data  = d;
    ld_last  = l;
    reload   = r;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    check_all(10'd0);
    tick();
    rst_n = 1'b1;
    check_all(10'd0);

    // Three-word program with ld_last on the third
    drive(1'b1, 32'h0050_0093, 1'b0, 1'b0); check_all(10'd0);
    drive(1'b1, 32'h00A0_0113, 1'b0, 1'b0); check_all(10'd4);
    drive(1'b1, 32'h0020_81B3, 1'b1, 1'b0); check_all(10'd8);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_all(10'd0); check_all(10'd4); check_all(10'd8); check_all(10'd12);

    // Stream past the small memory's capacity without ld_last
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    drive(1'b1, 32'h44, 1'b0, 1'b0); check_all(10'd12);
    drive(1'b1, 32'h55, 1'b0, 1'b0); check_all(10'd12);
    drive(1'b1, 32'h55, 1'b0, 1'b0); check_all(10'd12); check_all(10'd0);

    // Reload with an offer on the same edge, then accept it next edge
    ld_valid = 1'b0;
    drive(1'b1, 32'hAA, 1'b0, 1'b1); check_all(10'd0);
    drive(1'b1, 32'hAA, 1'b0, 1'b0); check_all(10'd0);
    drive(1'b1, 32'hBB, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_all(10'd5); check_all(10'd4); check_all(10'd0);

    // Stale words beyond a shorter reload are masked
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
    drive(1'b1, 32'hC0DE_0002, 1'b0, 1'b0);
    drive(1'b1, 32'hC0DE_0003, 1'b0, 1'b0);
    drive(1'b1, 32'hC0DE_0004, 1'b1, 1'b0); check_all(10'd12);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'hD00D_0001, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_all(10'd0); check_all(10'd4); check_all(10'd8); check_all(10'd12);

    // Asynchronous reset mid-load
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'hE000_0001, 1'b0, 1'b0);
    drive(1'b1, 32'hE000_0002, 1'b0, 1'b0);
    ld_valid = 1'b0;
    #4;
    rst_n = 1'b0;
    model_reset();
    check_all(10'd0);
    #3;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'hF000_0001, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_all(10'd0); check_all(10'd4);

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 15) == 0));
      check_all(10'($urandom_range(0, 1023)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_instr_mem.md
# boot_instr_mem

Parametrised instruction memory for the single-cycle RISC-V core. It is loaded word-by-word through a valid/ready boot port after reset or on request, then serves combinational fetches to the core's PC. Fetches return a NOP fill word while loading and for any word beyond the loaded program. It also flags misaligned fetches and illegal load attempts.

## Interface
- DEPTH, 256, number of XLEN-bit words; power of two, ≥ 2
- XLEN, 32, instruction word width
- FILL_WORD, 32'h0000_0013, word returned for unloaded or out-of-program fetches (`addi x0,x0,0`)
- AW (localparam), $clog2(DEPTH), word-index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reload  in  1  pulse; restarts loading from word 0
- ld_valid  in  1  load word present
- ld_ready  out  1  block accepts load words
- ld_data  in  XLEN  instruction word to store
- ld_last  in  1  marks the final word of the program
- A  in  AW+2  byte address from PC
- RD  out  XLEN  fetched instruction (combinational)
- misaligned  out  1  A[1:0] != 0 (combinational)
- boot_done  out  1  program loaded; the core may run
- ld_count  out  AW+1  number of words loaded (0..DEPTH)
- ld_overflow  out  1  sticky: load word offered while not loading

## Operation
- FSM has two states: LOAD and RUN. `ld_ready = (state==LOAD)`. `boot_done = (state==RUN)`.
- Load handshake: a word is accepted on a rising edge with `ld_valid & ld_ready`.
  - The accepted word is written to `mem[ld_count[AW-1:0]]`.
  - `ld_count` increments by 1.
- LOAD→RUN occurs on the accepting edge if `ld_last=1` or `ld_count==DEPTH-1` (memory full).
  - `ld_count` then equals the number of stored words, never more than DEPTH.
  - No wrap: a word is never written past index DEPTH-1.
- RUN→LOAD occurs on any edge with `reload=1`. On that edge `ld_count` clears to 0 and `ld_overflow` clears.
- `reload` in LOAD also restarts: `ld_count` returns to 0.
- `reload` beats `ld_valid` on the same edge. The offered word is not written and not acknowledged, and the source must hold it.
- `ld_overflow` sets on any edge in RUN with `ld_valid=1` and `reload=0`. It stays set until `reload` or reset.
- Fetch uses word index `w = A[AW+1:2]`.
  - RD = `mem[w]` if `state==RUN` and `w < ld_count`.
  - Otherwise RD = FILL_WORD.
- `misaligned = |A[1:0]`. RD still uses `w`; the low bits are ignored.
- Memory contents are not reset. Stale words beyond `ld_count` are masked by the fill rule.

## Timing
- Reset values (async, immediate on `rst_n=0`):
  - state = LOAD, `ld_ready=1`, `boot_done=0`
  - `ld_count=0`, `ld_overflow=0`
  - RD = FILL_WORD
- Reset mid-load discards progress. After release, loading restarts at word 0.
- Throughput is one load word per cycle with `ld_valid` held high.
- `boot_done` rises, and `ld_ready` falls, in the cycle after the edge that accepts the final word.
- Fetch latency is zero cycles. RD and `misaligned` are purely combinational from A, state, `ld_count` and memory.
- A word written on edge N is readable from the cycle after edge N, subject to the RUN condition.
- `ld_count` updates on the accepting edge and is a registered output.

## Test plan
- **Reset and program load:** With DEPTH=256, hold reset, then release and load 3 words 0x00500093, 0x00A00113, 0x002081B3 with `ld_last` on the third.
  - Expect `ld_ready=1` and RD=0x00000013 before `ld_last`.
  - Then `boot_done=1` one cycle after the third accept, and `ld_count=3`.
  - Expect A=0/4/8 to return the three words, and A=12 to return 0x00000013.
- **Full memory without ld_last:** With DEPTH=4, stream 6 words 0x11..0x66 with `ld_last=0`.
  - Expect only 0x11–0x44 accepted and `ld_count=4`.
  - Expect RUN entered after the 4th word, with `ld_ready=0` while 0x55 is held.
  - Expect `ld_overflow=1` one edge later. A=12 returns 0x44; A=0 returns 0x11 (no wrap overwrite).
- **Reload with simultaneous valid:** In RUN with `ld_overflow=1`, pulse `reload` while `ld_valid=1` and `ld_data=0xAA`.
  - Expect `ld_count=0`, `ld_overflow=0`, `boot_done=0`, and 0xAA not written.
  - On the next edge 0xAA is accepted at index 0.
- **Misaligned fetch:** In RUN with 2 words loaded, drive A=5.
  - Expect `misaligned=1` and RD = word 1.
  - Drive A=4: expect `misaligned=0` and the same RD.
- **Reset mid-load:** After 2 of 5 words are accepted, assert `rst_n=0` asynchronously between edges.
  - Expect `ld_count=0`, `boot_done=0` and RD=0x00000013 immediately.
  - After release, a reload of 1 word with `ld_last` gives `ld_count=1`.
- **Stale-data masking:** Load 4 words, reload, then load 1 word.
  - Expect A=4..12 to return FILL_WORD even though the old words remain in the array.
